reorder_buffer_mp: RTL and testbench

Parametrised, multi-port successor to the single-slot reorder buffer in the OoO RISC-V core. Allocates one entry per cycle in program order from rename/dispatch. Accepts NUM_CPL out-of-order completions per cycle, tagged by ROB index, from the ALUs and the LSQ. Retires up to RETIRE_W completed entries per cycle in order to the ARF, free list and LSQ.

---
 rtl/reorder_buffer_mp_if.sv | 55 +++++
 rtl/reorder_buffer_mp.sv | 201 ++++++++++++++++++++
 tb/tb_reorder_buffer_mp.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_mp_if.sv
// Dispatch / completion / retire bundle of the multi-port reorder buffer.
// Optional ROB_FLUSH_EN adds a pipeline flush strobe.
interface reorder_buffer_mp_if #(
  parameter int DEPTH    = 16,
  parameter int NUM_CPL  = 4,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = 6,
  parameter int XLEN     = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                       dis_valid;
  logic                       dis_ready;
  logic [XLEN-1:0]            dis_pc;
  logic [PREG_W-1:0]          dis_dr_p;
  logic [PREG_W-1:0]          dis_old_dr_p;
  logic                       dis_reg_write;
  logic                       dis_is_store;
  logic [IDX_W-1:0]           dis_rob_idx;
  logic [NUM_CPL-1:0]         cpl_valid;
  logic [NUM_CPL*IDX_W-1:0]   cpl_idx;
  logic [NUM_CPL*XLEN-1:0]    cpl_data;
  logic [RETIRE_W-1:0]        ret_valid;
  logic [RETIRE_W*XLEN-1:0]   ret_pc;
  logic [RETIRE_W*PREG_W-1:0] ret_dr_p;
  logic [RETIRE_W*PREG_W-1:0] ret_old_dr_p;
  logic [RETIRE_W*XLEN-1:0]   ret_data;
  logic [RETIRE_W-1:0]        ret_reg_write;
  logic [RETIRE_W-1:0]        ret_is_store;
  logic [IDX_W:0]             count;
  logic                       empty;
`ifdef ROB_FLUSH_EN
  logic                       flush;
`endif

  modport master (
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    output dis_valid, dis_pc, dis_dr_p, dis_old_dr_p, dis_reg_write, dis_is_store,
    output cpl_valid, cpl_idx, cpl_data,
    input  dis_ready, dis_rob_idx, ret_valid, ret_pc, ret_dr_p, ret_old_dr_p,
    input  ret_data, ret_reg_write, ret_is_store, count, empty
  );

  modport slave (
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    input  dis_valid, dis_pc, dis_dr_p, dis_old_dr_p, dis_reg_write, dis_is_store,
    input  cpl_valid, cpl_idx, cpl_data,
    output dis_ready, dis_rob_idx, ret_valid, ret_pc, ret_dr_p, ret_old_dr_p,
    output ret_data, ret_reg_write, ret_is_store, count, empty
  );
endinterface

// File: rtl/reorder_buffer_mp.sv
// Multi-port reorder buffer: in-order allocate, NUM_CPL out-of-order completions,
// up to RETIRE_W in-order retirements per cycle. Optional flush via ROB_FLUSH_EN.
module reorder_buffer_mp #(
  parameter int DEPTH    = 16,
  parameter int NUM_CPL  = 4,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = 6,
  parameter int XLEN     = 32
) (
  input logic                clk,
  input logic                rstn,
  reorder_buffer_mp_if.slave rob
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  done_r;
  logic [DEPTH-1:0]  regWrite_r;
  logic [DEPTH-1:0]  isStore_r;
  logic [XLEN-1:0]   pc_r     [DEPTH];
  logic [XLEN-1:0]   data_r   [DEPTH];
  logic [PREG_W-1:0] drP_r    [DEPTH];
  logic [PREG_W-1:0] oldDrP_r [DEPTH];
  idx_t              headPtr_r;
  idx_t              tailPtr_r;
  cnt_t              count_r;

  logic [RETIRE_W-1:0]        retValid_r;
  logic [RETIRE_W*XLEN-1:0]   retPc_r;
  logic [RETIRE_W*PREG_W-1:0] retDrP_r;
  logic [RETIRE_W*PREG_W-1:0] retOldDrP_r;
  logic [RETIRE_W*XLEN-1:0]   retData_r;
  logic [RETIRE_W-1:0]        retRegWrite_r;
  logic [RETIRE_W-1:0]        retIsStore_r;

  logic                disReady_s;
  logic                disAccept_s;
  logic                flush_s;
  logic [NUM_CPL-1:0]  cplValid_s;
  idx_t                cplIdx_s  [NUM_CPL];
  logic [XLEN-1:0]     cplData_s [NUM_CPL];
  logic [RETIRE_W-1:0] retSel_s;
  idx_t                retIdx_s  [RETIRE_W];
  cnt_t                nRet_s;
  logic                stopScan_s;
  logic                storeSeen_s;

`ifdef ROB_FLUSH_EN
  assign flush_s = rob.flush;
`else
  assign flush_s = 1'b0;
`endif

  // Full is judged on registered count, so a slot freed this cycle is reused next cycle.
  assign disReady_s  = (count_r != cnt_t'(DEPTH));
  assign disAccept_s = rob.dis_valid & disReady_s;

  assign rob.dis_ready     = disReady_s;
  assign rob.dis_rob_idx   = tailPtr_r;
  assign rob.count         = count_r;
  assign rob.empty         = (count_r == cnt_t'(0));
  assign rob.ret_valid     = retValid_r;
  assign rob.ret_pc        = retPc_r;
  assign rob.ret_dr_p      = retDrP_r;
  assign rob.ret_old_dr_p  = retOldDrP_r;
  assign rob.ret_data      = retData_r;
  assign rob.ret_reg_write = retRegWrite_r;
  assign rob.ret_is_store  = retIsStore_r;

  // Unpack the flat completion buses into per-port fields.
  always_comb begin
    for (int p = 0; p < NUM_CPL; p++) begin
      cplValid_s[p] = rob.cpl_valid[p] & valid_r[rob.cpl_idx[p*IDX_W +: IDX_W]];
      cplIdx_s[p]   = rob.cpl_idx[p*IDX_W +: IDX_W];
      cplData_s[p]  = rob.cpl_data[p*XLEN +: XLEN];
    end
  end

  // Retire selection: contiguous done prefix from head, cut before a second store.
  always_comb begin
    retSel_s    = '0;
    nRet_s      = '0;
    stopScan_s  = 1'b0;
    storeSeen_s = 1'b0;
    for (int k = 0; k < RETIRE_W; k++) begin
      retIdx_s[k] = headPtr_r + idx_t'(k);
      if (stopScan_s) begin
        retSel_s[k] = 1'b0;
      end else if (valid_r[retIdx_s[k]] && done_r[retIdx_s[k]] &&
                   !(isStore_r[retIdx_s[k]] && storeSeen_s)) begin
        retSel_s[k] = 1'b1;
        nRet_s      = nRet_s + cnt_t'(1);
        storeSeen_s = storeSeen_s | isStore_r[retIdx_s[k]];
      end else begin
        stopScan_s  = 1'b1;
      end
    end
  end

  // Control state: pointers, occupancy and per-entry valid/done bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      headPtr_r <= '0;
      tailPtr_r <= '0;
      count_r   <= '0;
      valid_r   <= '0;
      done_r    <= '0;
    end else if (flush_s) begin
      headPtr_r <= '0;
      tailPtr_r <= '0;
      count_r   <= '0;
      valid_r   <= '0;
      done_r    <= '0;
    end else begin
      // Ascending port order: the highest-numbered port's write lands last.
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cplValid_s[p]) done_r[cplIdx_s[p]] <= 1'b1;
      end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (retSel_s[k]) valid_r[retIdx_s[k]] <= 1'b0;
      end
      if (disAccept_s) begin
        valid_r[tailPtr_r] <= 1'b1;
        done_r[tailPtr_r]  <= 1'b0;
      end
      headPtr_r <= headPtr_r + idx_t'(nRet_s);
      tailPtr_r <= tailPtr_r + idx_t'(disAccept_s);
      count_r   <= count_r + cnt_t'(disAccept_s) - nRet_s;
    end
  end

  // Entry payload: dispatch fields and completion result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regWrite_r <= '0;
      isStore_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_r[i]     <= '0;
        data_r[i]   <= '0;
        drP_r[i]    <= '0;
        oldDrP_r[i] <= '0;
      end
    end else if (!flush_s) begin
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cplValid_s[p]) data_r[cplIdx_s[p]] <= cplData_s[p];
      end
      if (disAccept_s) begin
        pc_r[tailPtr_r]       <= rob.dis_pc;
        drP_r[tailPtr_r]      <= rob.dis_dr_p;
        oldDrP_r[tailPtr_r]   <= rob.dis_old_dr_p;
        regWrite_r[tailPtr_r] <= rob.dis_reg_write;
        isStore_r[tailPtr_r]  <= rob.dis_is_store;
        data_r[tailPtr_r]     <= '0;
      end
    end
  end

  // Registered retire outputs; unused slots are forced to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retValid_r    <= '0;
      retPc_r       <= '0;
      retDrP_r      <= '0;
      retOldDrP_r   <= '0;
      retData_r     <= '0;
      retRegWrite_r <= '0;
      retIsStore_r  <= '0;
    end else if (flush_s) begin
      retValid_r    <= '0;
      retPc_r       <= '0;
      retDrP_r      <= '0;
      retOldDrP_r   <= '0;
      retData_r     <= '0;
      retRegWrite_r <= '0;
      retIsStore_r  <= '0;
    end else begin
      for (int k = 0; k < RETIRE_W; k++) begin
        if (retSel_s[k]) begin
          retValid_r[k]                   <= 1'b1;
          retPc_r[k*XLEN +: XLEN]         <= pc_r[retIdx_s[k]];
          retDrP_r[k*PREG_W +: PREG_W]    <= drP_r[retIdx_s[k]];
          retOldDrP_r[k*PREG_W +: PREG_W] <= oldDrP_r[retIdx_s[k]];
          retData_r[k*XLEN +: XLEN]       <= data_r[retIdx_s[k]];
          retRegWrite_r[k]                <= regWrite_r[retIdx_s[k]];
          retIsStore_r[k]                 <= isStore_r[retIdx_s[k]];
        end else begin
          retValid_r[k]                   <= 1'b0;
          retPc_r[k*XLEN +: XLEN]         <= '0;
          retDrP_r[k*PREG_W +: PREG_W]    <= '0;
          retOldDrP_r[k*PREG_W +: PREG_W] <= '0;
          retData_r[k*XLEN +: XLEN]       <= '0;
          retRegWrite_r[k]                <= 1'b0;
          retIsStore_r[k]                 <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Scoreboard bench for reorder_buffer_mp: dispatch pushes expected retirements,
// a negedge monitor pops and compares them in program order.
module tb_reorder_buffer_mp;
  localparam int DEPTH    = 16;
  localparam int NUM_CPL  = 4;
  localparam int RETIRE_W = 2;
  localparam int PREG_W   = 6;
  localparam int XLEN     = 32;
  localparam int IDX_W    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  dr;
    logic [5:0]  old;
    logic [31:0] data;
    logic        rw;
    logic        st;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  exp_t sbQ[$];
  int   nCompared = 0;
  int   nMismatch = 0;
  logic [3:0] expTail = 4'd0;

  reorder_buffer_mp_if #(.DEPTH(DEPTH), .NUM_CPL(NUM_CPL), .RETIRE_W(RETIRE_W),
                         .PREG_W(PREG_W), .XLEN(XLEN)) rob ();

  reorder_buffer_mp #(.DEPTH(DEPTH), .NUM_CPL(NUM_CPL), .RETIRE_W(RETIRE_W),
                      .PREG_W(PREG_W), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rob  (rob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clrCpl();
    rob.cpl_valid = '0;
    rob.cpl_idx   = '0;
    rob.cpl_data  = '0;
  endtask

  task automatic setCpl(input int p, input logic [3:0] idx, input logic [31:0] data);
    rob.cpl_valid[p]               = 1'b1;
    rob.cpl_idx[p*IDX_W +: IDX_W]  = idx;
    rob.cpl_data[p*XLEN +: XLEN]   = data;
  endtask

  task automatic dispatchOne(input logic [31:0] pc, input logic [5:0] dr, input logic [5:0] old,
                             input logic rw, input logic st, input logic [31:0] data);
    exp_t e;
    rob.dis_valid     = 1'b1;
    rob.dis_pc        = pc;
    rob.dis_dr_p      = dr;
    rob.dis_old_dr_p  = old;
    rob.dis_reg_write = rw;
    rob.dis_is_store  = st;
    check("disRobIdx", rob.dis_rob_idx, expTail);
    check("disReady", rob.dis_ready, 1'b1);
    e = '{pc: pc, dr: dr, old: old, data: data, rw: rw, st: st};
    sbQ.push_back(e);
    tick();
    rob.dis_valid = 1'b0;
    expTail++;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic doReset();
    rstn = 1'b0;
    rob.dis_valid = 1'b0;
    clrCpl();
    #1;
    check("rstRetValid", rob.ret_valid, 2'b00);
    check("rstRetPc", rob.ret_pc, 64'h0);
    check("rstCount", rob.count, 5'd0);
    check("rstEmpty", rob.empty, 1'b1);
    check("rstDisReady", rob.dis_ready, 1'b1);
    check("rstRobIdx", rob.dis_rob_idx, 4'd0);
    sbQ.delete();
    expTail = 4'd0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  // Monitor: pop one expected entry per valid retire slot.
  always @(negedge clk) begin
    exp_t e;
    int   stores;
    if (rstn && rob.ret_valid != '0) begin
      stores = 0;
      check("retPacked", ((rob.ret_valid + 1) & rob.ret_valid) == 0, 1'b1);
      for (int k = 0; k < RETIRE_W; k++) begin
        if (rob.ret_valid[k]) begin
          if (sbQ.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL retUnexpected: slot %0d pc 0x%0h with no expected entry",
                     k, rob.ret_pc[k*XLEN +: XLEN]);
          end else begin
            e = sbQ.pop_front();
            check("retPc", rob.ret_pc[k*XLEN +: XLEN], e.pc);
            check("retDrP", rob.ret_dr_p[k*PREG_W +: PREG_W], e.dr);
            check("retOldDrP", rob.ret_old_dr_p[k*PREG_W +: PREG_W], e.old);
            check("retData", rob.ret_data[k*XLEN +: XLEN], e.data);
            check("retRegWrite", rob.ret_reg_write[k], e.rw);
            check("retIsStore", rob.ret_is_store[k], e.st);
            stores += int'(rob.ret_is_store[k]);
          end
        end else begin
          check("idlePc", rob.ret_pc[k*XLEN +: XLEN], 32'h0);
          check("idleData", rob.ret_data[k*XLEN +: XLEN], 32'h0);
          check("idleDrP", rob.ret_dr_p[k*PREG_W +: PREG_W], 6'h0);
          check("idleStore", rob.ret_is_store[k], 1'b0);
        end
      end
      check("storesPerGroup", stores <= 1, 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rob.dis_valid     = 1'b0;
    rob.dis_pc        = '0;
    rob.dis_dr_p      = '0;
    rob.dis_old_dr_p  = '0;
    rob.dis_reg_write = 1'b0;
    rob.dis_is_store  = 1'b0;
`ifdef ROB_FLUSH_EN
    rob.flush         = 1'b0;
`endif
    clrCpl();
    repeat (2) @(posedge clk);
    #1;
    doReset();

    // In-order retire after out-of-order completion.
    dispatchOne(32'h0, 6'd10, 6'd1, 1'b1, 1'b0, 32'hA0);
    dispatchOne(32'h4, 6'd11, 6'd2, 1'b1, 1'b0, 32'hA4);
    dispatchOne(32'h8, 6'd12, 6'd3, 1'b0, 1'b0, 32'hA8);
    check("t1Count3", rob.count, 5'd3);
    clrCpl(); setCpl(0, 4'd2, 32'hA8); tick();
    clrCpl(); setCpl(0, 4'd0, 32'hA0); tick();
    clrCpl(); setCpl(0, 4'd1, 32'hA4); tick();
    check("t1Ret01", rob.ret_valid, 2'b01);
    check("t1Count2", rob.count, 5'd2);
    clrCpl(); tick();
    check("t1Ret11", rob.ret_valid, 2'b11);
    tick();
    check("t1RetIdle", rob.ret_valid, 2'b00);
    check("t1Count0", rob.count, 5'd0);
    check("t1Empty", rob.empty, 1'b1);
    check("t1Drained", sbQ.size(), 0);

    // Fill to full, hold dispatch while full, wrap the tail.
    doReset();
    for (int i = 0; i < 16; i++) begin
      dispatchOne(32'h100 + 32'(4 * i), 6'(i + 16), 6'(i), 1'(i), 1'b0, 32'h1000 + 32'(i));
    end
    check("t2Full", rob.count, 5'd16);
    check("t2NotReady", rob.dis_ready, 1'b0);
    rob.dis_valid = 1'b1;
    rob.dis_pc    = 32'hDEAD;
    tick(); tick();
    rob.dis_valid = 1'b0;
    check("t2HoldIdx", rob.dis_rob_idx, 4'd0);
    check("t2HoldCount", rob.count, 5'd16);
    setCpl(0, 4'd0, 32'h1000); tick();
    clrCpl(); tick();
    check("t2Ret01", rob.ret_valid, 2'b01);
    check("t2Count15", rob.count, 5'd15);
    check("t2ReadyAgain", rob.dis_ready, 1'b1);
    dispatchOne(32'h200, 6'd40, 6'd41, 1'b1, 1'b0, 32'h2000);
    for (int i = 1; i < 16; i++) begin
      clrCpl(); setCpl(0, 4'(i), 32'h1000 + 32'(i)); tick();
    end
    clrCpl(); setCpl(0, 4'd0, 32'h2000); tick();
    clrCpl(); repeat (3) tick();
    check("t2Count0", rob.count, 5'd0);
    check("t2Drained", sbQ.size(), 0);

    // Same-index completion on all ports; completion to an invalid entry.
    doReset();
    setCpl(1, 4'd9, 32'hBAD); tick();
    clrCpl();
    check("t3InvCount", rob.count, 5'd0);
    check("t3InvEmpty", rob.empty, 1'b1);
    for (int i = 0; i < 5; i++) begin
      dispatchOne(32'h400 + 32'(4 * i), 6'(i + 1), 6'(i + 33), 1'b1, 1'b0, 32'h50 + 32'(i));
    end
    dispatchOne(32'h414, 6'd20, 6'd21, 1'b1, 1'b0, 32'h44);
    for (int p = 0; p < 4; p++) setCpl(p, 4'(p), 32'h50 + 32'(p));
    tick();
    clrCpl(); setCpl(0, 4'd4, 32'h54); tick();
    clrCpl();
    setCpl(0, 4'd5, 32'h11); setCpl(1, 4'd5, 32'h22);
    setCpl(2, 4'd5, 32'h33); setCpl(3, 4'd5, 32'h44);
    tick();
    clrCpl();
    for (int i = 6; i < 10; i++) begin
      dispatchOne(32'h500 + 32'(4 * i), 6'(i), 6'(i + 7), 1'b0, 1'b0, 32'h60 + 32'(i));
    end
    for (int p = 0; p < 3; p++) setCpl(p, 4'(p + 6), 32'h66 + 32'(p));
    tick();
    clrCpl(); repeat (4) tick();
    check("t3Idx9Pending", rob.count, 5'd1);
    setCpl(0, 4'd9, 32'h69); tick();
    clrCpl(); repeat (3) tick();
    check("t3Count0", rob.count, 5'd0);
    check("t3Drained", sbQ.size(), 0);

    // Two stores at head retire in separate groups.
    doReset();
    dispatchOne(32'h300, 6'd1, 6'd2, 1'b0, 1'b1, 32'h31);
    dispatchOne(32'h304, 6'd3, 6'd4, 1'b0, 1'b1, 32'h32);
    dispatchOne(32'h308, 6'd5, 6'd6, 1'b1, 1'b0, 32'h33);
    setCpl(0, 4'd0, 32'h31); setCpl(1, 4'd1, 32'h32); setCpl(2, 4'd2, 32'h33);
    tick();
    clrCpl(); tick();
    check("t4Ret01", rob.ret_valid, 2'b01);
    check("t4Store01", rob.ret_is_store, 2'b01);
    tick();
    check("t4Ret11", rob.ret_valid, 2'b11);
    check("t4Store01b", rob.ret_is_store, 2'b01);
    tick();
    check("t4Drained", sbQ.size(), 0);

    // Reset mid-stream with eight entries and a retire group on the outputs.
    doReset();
    for (int i = 0; i < 8; i++) begin
      dispatchOne(32'h600 + 32'(4 * i), 6'(i), 6'(i + 8), 1'b1, 1'b0, 32'h70 + 32'(i));
    end
    setCpl(0, 4'd0, 32'h70); setCpl(1, 4'd1, 32'h71); tick();
    clrCpl(); tick();
    check("t5Ret11", rob.ret_valid, 2'b11);
    check("t5Count6", rob.count, 5'd6);
    doReset();

`ifdef ROB_FLUSH_EN
    // Flush beats dispatch, completion and a pending retire.
    dispatchOne(32'h700, 6'd1, 6'd2, 1'b1, 1'b0, 32'h80);
    dispatchOne(32'h704, 6'd3, 6'd4, 1'b1, 1'b0, 32'h81);
    setCpl(0, 4'd0, 32'h80); setCpl(1, 4'd1, 32'h81); tick();
    clrCpl();
    rob.flush     = 1'b1;
    rob.dis_valid = 1'b1;
    rob.dis_pc    = 32'hBEEF;
    setCpl(0, 4'd2, 32'h99);
    tick();
    rob.flush     = 1'b0;
    rob.dis_valid = 1'b0;
    clrCpl();
    sbQ.delete();
    expTail = 4'd0;
    check("t6Count0", rob.count, 5'd0);
    check("t6NoRetire", rob.ret_valid, 2'b00);
    check("t6Empty", rob.empty, 1'b1);
    dispatchOne(32'h800, 6'd9, 6'd10, 1'b1, 1'b0, 32'h90);
    setCpl(0, 4'd0, 32'h90); tick();
    clrCpl(); repeat (3) tick();
    check("t6Drained", sbQ.size(), 0);
`endif

    check("finalDrained", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
